eth_10g_mac_rx_st_error_adapter: RTL and testbench
==================================================

Name: eth_10g_mac_rx_st_error_adapter

Overview:
- RX-path counterpart of the TX pause-control error adapter. Sits between the 10G MAC RX Avalon-ST source and the client sink.
- Collapses the MAC's per-beat multi-bit RX error vector into a single client error bit, asserted only on the end-of-packet beat. Errors are accumulated sticky across the whole packet.
- Enforces SOP/EOP framing: drops orphan beats and counts framing violations.
- Registered output stage with a skid buffer, so `in_ready` is a flop and the timing paths are fully cut.

Parameters:
- DATA_W, 64, data bus width
- EMPTY_W, 3, empty field width (log2 of DATA_W/8)
- ERR_IN_W, 6, MAC RX error vector width. Bit map: [0] CRC, [1] length, [2] undersize, [3] oversize, [4] payload length, [5] PHY
- ERR_MASK, 6'b111111, error bits that contribute to `out_error`
- CNT_W, 16, statistics counter width (feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_ready  out  1  sink ready; registered
- in_valid  in  1  beat valid
- in_data  in  DATA_W  payload
- in_error  in  ERR_IN_W  per-beat MAC error flags
- in_startofpacket  in  1  SOP
- in_endofpacket  in  1  EOP
- in_empty  in  EMPTY_W  empty bytes, meaningful on EOP only
- out_ready  in  1  downstream ready
- out_valid  out  1  beat valid
- out_data  out  DATA_W  payload
- out_error  out  1  packet error, meaningful on EOP beat only
- out_startofpacket  out  1  SOP
- out_endofpacket  out  1  EOP
- out_empty  out  EMPTY_W  empty bytes
- cnt_clear  in  1  clears counters (feature only)
- cnt_err_pkts  out  CNT_W  errored packets (feature only)
- cnt_framing  out  CNT_W  framing violations (feature only)

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: `in_ready`=0 in the reset cycle, then 1. All `out_*`=0. Accumulator=0. FSM=IDLE. Counters=0.
- Handshake: a beat transfers when valid&ready on either side. Latency is 1 cycle from accepted input to `out_valid`. Throughput is 1 beat/cycle while `out_ready`=1.
- Skid buffer: output register plus one skid register.
  - An accepted beat goes to the skid register when the output register is held (out_valid & !out_ready).
  - `in_ready` next = !skid_valid_next.
  - Skid drains into the output register when the output transfers.
  - Ordering is always preserved. No beat is lost or duplicated under arbitrary `out_ready` toggling.
- Framing FSM (evaluated on accepted beats only):
  - IDLE, beat with SOP & EOP: forward; stay IDLE.
  - IDLE, beat with SOP & !EOP: forward; go to IN_PKT.
  - IDLE, beat without SOP: drop (not forwarded); count framing violation; stay IDLE.
  - IN_PKT, beat with !SOP & EOP: forward; go to IDLE.
  - IN_PKT, beat with !SOP & !EOP: forward; stay.
  - IN_PKT, beat with SOP: forward as the start of a new packet; count framing violation; clear accumulator; next state follows EOP as in IDLE. The truncated previous packet is not patched.
- Error accumulation: acc holds the sticky OR of `in_error` over the current packet's accepted beats.
  - On an EOP beat, the captured `out_error` = |((acc | in_error) & ERR_MASK). Acc is then cleared.
  - On non-EOP beats, the captured `out_error` = 0.
  - A SOP beat starts from acc=0; its own `in_error` is included.
- Data, empty, SOP and EOP pass through unmodified. `out_empty` is forced to 0 on non-EOP beats.
- Reset mid-packet: everything returns to reset values and the partial packet is discarded. The first post-reset non-SOP beat is dropped and counted.

Optional Feature:
- Macro: `RX_ERR_ADAPTER_STATS_EN`.
- Defined:
  - `cnt_err_pkts` increments on each forwarded EOP beat with `out_error`=1.
  - `cnt_framing` increments on each violation above.
  - Both counters saturate at all-ones (no wrap).
  - `cnt_clear` zeroes them synchronously. If clear and an increment occur in the same cycle, clear wins and the result is 0.
- Undefined: the counter ports and logic are absent; `cnt_clear` is absent.

Decomposition:
- Shared package `eth_10g_rx_pkg`: ERR_IN_W, error-bit index constants (ERR_CRC=0 … ERR_PHY=5), default ERR_MASK, FSM state enum {IDLE, IN_PKT}.
- One natural sub-module: `eth_10g_st_skid_buffer`, a generic two-register Avalon-ST pipeline stage parameterised on the payload width. The adapter packs {data, error, sop, eop, empty} into that payload.

Test Plan:
- 3-beat packet, `in_error` = 0, 6'h01 (CRC), 0; `out_ready`=1 -> 3 beats out at 1-cycle latency; `out_error`=1 on EOP only; data matches.
- 1-beat SOP+EOP, `in_error`=6'h20, ERR_MASK=6'h1F -> `out_error`=0. With ERR_MASK=6'h3F -> `out_error`=1.
- Stream of 8 back-to-back packets with `out_ready` pattern 1,0,0,1,0,1… -> beats emerge in order with no loss or duplication; `in_ready` deasserts only while the skid is full.
- Framing: non-SOP beat in IDLE, then SOP, data, SOP+EOP -> first beat dropped; second SOP is forwarded; `cnt_framing`=2; the new packet's error is unaffected by the earlier error bits.
- Reset asserted mid-packet with acc nonzero -> `out_valid`=0 next cycle; the next clean SOP/EOP packet gives `out_error`=0.
- Stats (feature on): CNT_W=4, 20 errored packets -> `cnt_err_pkts`=15 (saturated). Pulse `cnt_clear` together with an errored EOP -> count reads 0.

Source files
------------

// File: rtl/eth_10g_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_10g_rx_pkg
// Purpose  : Shared constants and types for the 10G MAC RX client adapters:
//            the MAC error-vector bit map, the default error mask and the
//            packet-framing state type.
// Revision : 1.0 - initial release
// ============================================================================
package eth_10g_rx_pkg;

    localparam int ERR_IN_W        = 6;

    localparam int ERR_CRC         = 0;
    localparam int ERR_LEN         = 1;
    localparam int ERR_UNDERSIZE   = 2;
    localparam int ERR_OVERSIZE    = 3;
    localparam int ERR_PAYLOAD_LEN = 4;
    localparam int ERR_PHY         = 5;

    localparam logic [ERR_IN_W-1:0] ERR_MASK_DFLT = ERR_IN_W'(
        (1 << ERR_CRC) | (1 << ERR_LEN) | (1 << ERR_UNDERSIZE) |
        (1 << ERR_OVERSIZE) | (1 << ERR_PAYLOAD_LEN) | (1 << ERR_PHY));

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_10g_st_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : eth_10g_st_skid_buffer
// Purpose  : Generic Avalon-ST pipeline stage (output register plus one skid
//            register). in_ready is registered so both paths are cut.
// Revision : 1.0 - initial release
// ============================================================================
module eth_10g_st_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_payload,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_payload
);

    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_out_payload;
    logic [WIDTH-1:0] r_skid_payload;

    logic             w_in_xfer;
    logic             w_out_free;
    logic             w_skid_valid_nxt;

    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_free = ~r_out_valid | out_ready;

    // in_ready is low exactly while the skid holds a beat, so a new beat
    // and a skid drain never compete for the output register.
    always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        if (r_skid_valid && w_out_free)
            w_skid_valid_nxt = 1'b0;
        else if (w_in_xfer && !w_out_free)
            w_skid_valid_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready     <= 1'b0;
            r_out_valid    <= 1'b0;
            r_skid_valid   <= 1'b0;
            r_out_payload  <= '0;
            r_skid_payload <= '0;
        end else begin
            r_in_ready   <= ~w_skid_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_in_xfer && !w_out_free)
                r_skid_payload <= in_payload;
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid   <= 1'b1;
                    r_out_payload <= r_skid_payload;
                end else begin
                    r_out_valid <= w_in_xfer;
                    if (w_in_xfer)
                        r_out_payload <= in_payload;
                end
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_payload = r_out_payload;

endmodule
`default_nettype wire

// File: rtl/eth_10g_mac_rx_st_error_adapter.sv
`default_nettype none
// ============================================================================
// Module   : eth_10g_mac_rx_st_error_adapter
// Purpose  : Collapses the MAC RX error vector into one EOP error bit,
//            enforces SOP/EOP framing and registers the client stream.
//            Optional statistics: define RX_ERR_ADAPTER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
import eth_10g_rx_pkg::*;

module eth_10g_mac_rx_st_error_adapter #(
    parameter int                   DATA_W   = 64,
    parameter int                   EMPTY_W  = 3,
    parameter int                   ERR_IN_W = eth_10g_rx_pkg::ERR_IN_W,
    parameter logic [ERR_IN_W-1:0]  ERR_MASK = ERR_MASK_DFLT
`ifdef RX_ERR_ADAPTER_STATS_EN
    ,
    parameter int                   CNT_W    = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    output logic                in_ready,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [ERR_IN_W-1:0] in_error,
    input  logic                in_startofpacket,
    input  logic                in_endofpacket,
    input  logic [EMPTY_W-1:0]  in_empty,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_error,
    output logic                out_startofpacket,
    output logic                out_endofpacket,
    output logic [EMPTY_W-1:0]  out_empty
`ifdef RX_ERR_ADAPTER_STATS_EN
    ,
    input  logic                cnt_clear,
    output logic [CNT_W-1:0]    cnt_err_pkts,
    output logic [CNT_W-1:0]    cnt_framing
`endif
);

    localparam int PAY_W = DATA_W + 3 + EMPTY_W;

    rx_state_e             r_state;
    rx_state_e             w_state_nxt;
    logic [ERR_IN_W-1:0]   r_acc;
    logic [ERR_IN_W-1:0]   w_acc_nxt;
    logic                  w_accept;
    logic                  w_fwd;
    logic                  w_err_bit;
    logic                  w_framing_viol;
    logic [PAY_W-1:0]      w_in_payload;
    logic [PAY_W-1:0]      w_out_payload;

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // A SOP always restarts accumulation from its own error bits, which also
    // discards whatever a truncated previous packet had collected.
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_fwd          = 1'b0;
        w_err_bit      = 1'b0;
        w_framing_viol = 1'b0;
        if (w_accept) begin
            if (in_startofpacket) begin
                w_fwd          = 1'b1;
                w_framing_viol = (r_state == IN_PKT);
                if (in_endofpacket) begin
                    w_err_bit   = |(in_error & ERR_MASK);
                    w_acc_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_acc_nxt   = in_error;
                    w_state_nxt = IN_PKT;
                end
            end else if (r_state == IDLE) begin
                w_framing_viol = 1'b1;
            end else begin
                w_fwd = 1'b1;
                if (in_endofpacket) begin
                    w_err_bit   = |((r_acc | in_error) & ERR_MASK);
                    w_acc_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_acc_nxt   = r_acc | in_error;
                end
            end
        end
    end

    assign w_in_payload = {in_data, w_err_bit, in_startofpacket, in_endofpacket,
                           in_endofpacket ? in_empty : {EMPTY_W{1'b0}}};

    eth_10g_st_skid_buffer #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (w_fwd),
        .in_ready    (in_ready),
        .in_payload  (w_in_payload),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_payload (w_out_payload)
    );

    assign {out_data, out_error, out_startofpacket, out_endofpacket, out_empty} = w_out_payload;

`ifdef RX_ERR_ADAPTER_STATS_EN
    logic [CNT_W-1:0] r_cnt_err_pkts;
    logic [CNT_W-1:0] r_cnt_framing;
    logic             w_err_pkt;

    assign w_err_pkt = w_fwd & in_endofpacket & w_err_bit;

    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            r_cnt_err_pkts <= '0;
            r_cnt_framing  <= '0;
        end else begin
            if (w_err_pkt && (r_cnt_err_pkts != {CNT_W{1'b1}}))
                r_cnt_err_pkts <= r_cnt_err_pkts + 1'b1;
            if (w_framing_viol && (r_cnt_framing != {CNT_W{1'b1}}))
                r_cnt_framing <= r_cnt_framing + 1'b1;
        end
    end

    assign cnt_err_pkts = r_cnt_err_pkts;
    assign cnt_framing  = r_cnt_framing;
`else
    logic w_unused_viol;
    assign w_unused_viol = w_framing_viol;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eth_10g_mac_rx_st_error_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_10g_mac_rx_st_error_adapter
// Purpose  : Directed self-checking bench for the RX error adapter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_10g_mac_rx_st_error_adapter;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_ready, in_valid;
    logic [63:0] in_data;
    logic [5:0]  in_error;
    logic        in_sop, in_eop;
    logic [2:0]  in_empty;
    logic        out_ready;
    logic        out_valid, out_error, out_sop, out_eop;
    logic [63:0] out_data;
    logic [2:0]  out_empty;

    logic        m_in_ready, m_out_valid, m_out_error, m_out_sop, m_out_eop;
    logic [63:0] m_out_data;
    logic [2:0]  m_out_empty;

`ifdef RX_ERR_ADAPTER_STATS_EN
    logic        cnt_clear;
    logic [3:0]  cnt_err_pkts, cnt_framing;
    logic [15:0] m_cnt_err_pkts, m_cnt_framing;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    eth_10g_mac_rx_st_error_adapter #(
        .DATA_W(64), .EMPTY_W(3), .ERR_IN_W(6), .ERR_MASK(6'h3F)
`ifdef RX_ERR_ADAPTER_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
        .in_data(in_data), .in_error(in_error), .in_startofpacket(in_sop),
        .in_endofpacket(in_eop), .in_empty(in_empty), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
        .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty)
`ifdef RX_ERR_ADAPTER_STATS_EN
        , .cnt_clear(cnt_clear), .cnt_err_pkts(cnt_err_pkts), .cnt_framing(cnt_framing)
`endif
    );

    eth_10g_mac_rx_st_error_adapter #(
        .DATA_W(64), .EMPTY_W(3), .ERR_IN_W(6), .ERR_MASK(6'h1F)
    ) dut_m (
        .clk(clk), .reset(reset), .in_ready(m_in_ready), .in_valid(in_valid),
        .in_data(in_data), .in_error(in_error), .in_startofpacket(in_sop),
        .in_endofpacket(in_eop), .in_empty(in_empty), .out_ready(out_ready),
        .out_valid(m_out_valid), .out_data(m_out_data), .out_error(m_out_error),
        .out_startofpacket(m_out_sop), .out_endofpacket(m_out_eop), .out_empty(m_out_empty)
`ifdef RX_ERR_ADAPTER_STATS_EN
        , .cnt_clear(cnt_clear), .cnt_err_pkts(m_cnt_err_pkts), .cnt_framing(m_cnt_framing)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output word: {valid, data, error, sop, eop, empty}
    function automatic logic [127:0] ow(input logic v, input logic [63:0] d, input logic e,
                                        input logic s, input logic eo, input logic [2:0] em);
        return 128'({v, d, e, s, eo, em});
    endfunction

    function automatic logic [127:0] obs_w();
        return 128'({out_valid, out_data, out_error, out_sop, out_eop, out_empty});
    endfunction

    task automatic drive(input logic v, input logic [63:0] d, input logic [5:0] e,
                         input logic s, input logic eo, input logic [2:0] em);
        in_valid = v; in_data = d; in_error = e; in_sop = s; in_eop = eo; in_empty = em;
        @(posedge clk); #1;
    endtask

    // Streaming scoreboard storage
    localparam int NB = 15;
    logic [69:0] st_beat [NB];
    logic [5:0]  st_err  [NB];
    logic [69:0] st_exp  [NB];

    initial begin
        logic [5:0] pat;
        logic [5:0] acc_m;
        logic [5:0] acc_b;
        int         k, r, pk, pos, plen;

        reset = 1'b1; out_ready = 1'b1;
        in_valid = 0; in_data = '0; in_error = '0; in_sop = 0; in_eop = 0; in_empty = '0;
`ifdef RX_ERR_ADAPTER_STATS_EN
        cnt_clear = 1'b0;
`endif
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out", obs_w(), ow(0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_in_ready", in_ready, 1);

        // 3-beat packet, CRC error on the middle beat
        drive(1, 64'hA1, 6'h00, 1, 0, 3'd3);
        chk("pkt3_b0", obs_w(), ow(1, 64'hA1, 0, 1, 0, 0));
        drive(1, 64'hA2, 6'h01, 0, 0, 3'd0);
        chk("pkt3_b1", obs_w(), ow(1, 64'hA2, 0, 0, 0, 0));
        drive(1, 64'hA3, 6'h00, 0, 1, 3'd5);
        chk("pkt3_b2", obs_w(), ow(1, 64'hA3, 1, 0, 1, 5));
        drive(0, 0, 0, 0, 0, 0);
        chk("pkt3_idle", out_valid, 0);

        // PHY error against two masks
        drive(1, 64'hB0, 6'h20, 1, 1, 3'd7);
        chk("phy_mask3f", obs_w(), ow(1, 64'hB0, 1, 1, 1, 7));
        chk("phy_mask1f", m_out_error, 0);

        // Framing: orphan beat, then SOP, data, SOP+EOP
`ifdef RX_ERR_ADAPTER_STATS_EN
        cnt_clear = 1'b1;
`endif
        drive(0, 0, 0, 0, 0, 0);
`ifdef RX_ERR_ADAPTER_STATS_EN
        cnt_clear = 1'b0;
`endif
        drive(1, 64'hC0, 6'h01, 0, 0, 3'd0);
        chk("orphan_drop", out_valid, 0);
        drive(1, 64'hC1, 6'h02, 1, 0, 3'd0);
        chk("frm_sop", obs_w(), ow(1, 64'hC1, 0, 1, 0, 0));
        drive(1, 64'hC2, 6'h00, 0, 0, 3'd0);
        chk("frm_data", obs_w(), ow(1, 64'hC2, 0, 0, 0, 0));
        drive(1, 64'hC3, 6'h00, 1, 1, 3'd2);
        chk("frm_resync", obs_w(), ow(1, 64'hC3, 0, 1, 1, 2));
        drive(0, 0, 0, 0, 0, 0);
`ifdef RX_ERR_ADAPTER_STATS_EN
        chk("cnt_framing", cnt_framing, 2);
        chk("cnt_err_none", cnt_err_pkts, 0);
`endif

        // Reset in the middle of a packet with errors accumulated
        drive(1, 64'hD0, 6'h04, 1, 0, 3'd0);
        chk("mid_sop", obs_w(), ow(1, 64'hD0, 0, 1, 0, 0));
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_reset_out", out_valid, 0);
        chk("mid_reset_ready", in_ready, 0);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 64'hD1, 6'h00, 0, 1, 3'd0);
        chk("post_reset_orphan", out_valid, 0);
        drive(1, 64'hD2, 6'h00, 1, 1, 3'd1);
        chk("post_reset_clean", obs_w(), ow(1, 64'hD2, 0, 1, 1, 1));
        drive(0, 0, 0, 0, 0, 0);
`ifdef RX_ERR_ADAPTER_STATS_EN
        chk("post_reset_cnt", cnt_framing, 1);
`endif

        // 8 back-to-back packets (lengths 1,2,3,...) under out_ready pattern 1,0,0,1,0,1
        k = 0; acc_m = '0;
        for (int p = 0; p < 8; p++) begin
            plen = (p % 3) + 1;
            for (int b = 0; b < plen; b++) begin
                st_err[k]  = ((k % 4) == 1) ? 6'h08 : 6'h00;
                st_beat[k] = {64'hF000 + 64'(k), 1'b0, (b == 0), (b == plen - 1), 3'(k % 8)};
                acc_b = (b == 0) ? st_err[k] : (acc_m | st_err[k]);
                if (b == plen - 1) begin
                    st_exp[k] = {64'hF000 + 64'(k), |acc_b, (b == 0), 1'b1, 3'(k % 8)};
                    acc_m = '0;
                end else begin
                    st_exp[k] = {64'hF000 + 64'(k), 1'b0, (b == 0), 1'b0, 3'd0};
                    acc_m = acc_b;
                end
                k++;
            end
        end

        pat = 6'b101001;
        k = 0; r = 0;
        for (int cyc = 0; cyc < 300 && r < NB; cyc++) begin
            pos = cyc % 6;
            out_ready = pat[pos];
            if (k < NB) begin
                in_valid = 1'b1;
                {in_data, in_sop, in_eop, in_empty} = {st_beat[k][69:6], st_beat[k][4:0]};
                in_error = st_err[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready)
                chk("skid_full_implies_out_held", out_valid, 1);
            if (out_valid && out_ready) begin
                chk("stream_beat", 128'({out_data, out_error, out_sop, out_eop, out_empty}),
                    128'(st_exp[r]));
                r++;
            end
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        chk("stream_count", r, NB);
        in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("stream_drained", out_valid, 0);

`ifdef RX_ERR_ADAPTER_STATS_EN
        cnt_clear = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        cnt_clear = 1'b0;
        for (int i = 0; i < 20; i++)
            drive(1, 64'hE0 + 64'(i), 6'h01, 1, 1, 3'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk("cnt_err_saturate", cnt_err_pkts, 4'hF);
        cnt_clear = 1'b1;
        drive(1, 64'hEF, 6'h01, 1, 1, 3'd0);
        cnt_clear = 1'b0;
        chk("cnt_clear_wins", cnt_err_pkts, 0);
        drive(0, 0, 0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
